mult_div_seq: RTL
=================

MULT_DIV_SEQ -- requirements
Module: mult_div_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and result width in bits.
REQ-002 SHALL have port clock  input  1  system clock, all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset (reset=0 resets on the next rising clock edge).
REQ-004 SHALL have port start  input  1  request strobe from the control FSM, sampled only in IDLE.
REQ-005 SHALL have port op  input  1  0 = signed multiply (MULT), 1 = signed divide (DIV).
REQ-006 SHALL have port opA  input  WIDTH  multiplicand / dividend, sampled with start.
REQ-007 SHALL have port opB  input  WIDTH  multiplier / divisor, sampled with start.
REQ-008 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-009 SHALL have port done  output  1  registered one-cycle completion pulse.
REQ-010 SHALL have port hi_out  output  WIDTH  HI result: product upper half or remainder.
REQ-011 SHALL have port lo_out  output  WIDTH  LO result: product lower half or quotient.
REQ-012 SHALL have port div_zero  output  1  one-cycle pulse coincident with done on divide by zero.

Function
REQ-013 SHALL implement states IDLE, RUN and FIN, plus a 6-bit iteration counter.
REQ-014 In IDLE with start=1 at edge k, the block SHALL latch op, opA and opB, clear the counter, and enter RUN.
REQ-015 RUN SHALL perform one iteration per cycle on edges k+1..k+WIDTH and enter FIN on edge k+WIDTH.
- MULT: radix-2 Booth add/subtract-shift.
- DIV: restoring shift-subtract on magnitudes.
REQ-016 On the FIN edge (k+WIDTH+1), the block SHALL write hi_out/lo_out, set done=1 for exactly one cycle, and return to IDLE.
REQ-017 MULT SHALL produce the full signed 2*WIDTH product: hi_out = upper half, lo_out = lower half.
REQ-018 DIV SHALL produce a quotient truncated toward zero in lo_out and a remainder carrying the sign of the dividend in hi_out.
REQ-019 DIV with opA=0x80000000 and opB=0xFFFFFFFF SHALL give lo_out=0x80000000 and hi_out=0 (wrap, no flag).
REQ-020 DIV with opB=0 SHALL skip RUN and go IDLE->FIN at edge k.
- At edge k+1: done=1, div_zero=1, hi_out/lo_out unchanged.
REQ-021 start while busy=1 SHALL be ignored, and the latched operands SHALL be unaffected.
REQ-022 start SHALL be accepted in the same cycle that done is high, since the state is already IDLE.
REQ-023 hi_out/lo_out SHALL hold their values between operations and change only on the FIN edge.
REQ-024 busy SHALL be combinationally derived from the state; done and div_zero SHALL be registered.

Reset
REQ-025 reset=0 at any edge, including mid-RUN, SHALL force IDLE, counter=0, hi_out=0, lo_out=0, done=0, div_zero=0, busy=0, and SHALL discard any in-progress operation.
REQ-026 start coincident with reset=0 SHALL be ignored.

Configuration
REQ-027 Macro MULT_DIV_SEQ_DIV_EN SHALL control divide support.
- Defined: DIV behaves per REQ-015..REQ-020.
- Undefined: divider datapath omitted; op=1 with start in IDLE goes directly to FIN; one cycle later done=1 with div_zero=0 and hi_out/lo_out unchanged; MULT unaffected.

Verification
REQ-028 MULT opA=7, opB=0xFFFFFFFD -> hi_out=0xFFFFFFFF, lo_out=0xFFFFFFEB; done high exactly WIDTH+1 edges after the start edge; busy high throughout.
REQ-029 MULT opA=opB=0x80000000 -> hi_out=0x40000000, lo_out=0x00000000.
REQ-030 DIV opA=0xFFFFFFF9 (-7), opB=2 -> lo_out=0xFFFFFFFD, hi_out=0xFFFFFFFF; div_zero=0.
REQ-031 DIV opB=0 with prior hi_out/lo_out=0x11/0x22 -> done=1 and div_zero=1 one edge after start; hi_out/lo_out remain 0x11/0x22.
REQ-032 Start MULT 5*6, then pulse start with DIV 9/3 at cycle 10 -> second request ignored; result is hi_out=0, lo_out=30.
REQ-033 Start MULT, then reset=0 at cycle 15 -> next cycle busy=0, hi_out=lo_out=0, and no done pulse follows.

Source files
------------

// File: rtl/mult_div_seq.sv
// Sequential signed multiply (radix-2 Booth) / divide (restoring, on magnitudes).
// Divide support is compiled in only when MULT_DIV_SEQ_DIV_EN is defined.
module mult_div_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             div_zero
);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_e;

    localparam logic [5:0] LAST_ITER = 6'(WIDTH - 1);

    state_e           state, stateNext;
    logic [5:0]       count;
    logic             noWrite, zeroFlag;
    logic             skipRun, zeroReq, finNow;
    logic [WIDTH:0]   acc, mExt, boothSum, boothAcc;
    logic [WIDTH-1:0] lowReg, mReg, boothLow;
    logic             qm1;

`ifdef MULT_DIV_SEQ_DIV_EN
    logic             opDiv, negQuo, negRem;
    logic [WIDTH:0]   divShift, divTrial, divAcc;
    logic [WIDTH-1:0] divLow;

    function automatic logic [WIDTH-1:0] magOf(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    assign skipRun = op && (opB == '0);
    assign zeroReq = skipRun;
`else
    // Without the divider a DIV request completes immediately with no result.
    assign skipRun = op;
    assign zeroReq = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!reset) state <= IDLE;
        else        state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE: if (start) stateNext = skipRun ? FIN : RUN;
            RUN:  if (count == LAST_ITER) stateNext = FIN;
            FIN:  stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        busy   = (state != IDLE);
        finNow = (state == FIN);
    end

    // acc carries one guard bit so subtracting the most negative multiplicand cannot overflow.
    assign mExt = {mReg[WIDTH-1], mReg};

    always_comb begin
        boothSum = acc;
        unique case ({lowReg[0], qm1})
            2'b10:   boothSum = acc - mExt;
            2'b01:   boothSum = acc + mExt;
            default: boothSum = acc;
        endcase
        boothAcc = {boothSum[WIDTH], boothSum[WIDTH:1]};
        boothLow = {boothSum[0], lowReg[WIDTH-1:1]};
    end

`ifdef MULT_DIV_SEQ_DIV_EN
    // Remainder stays below the divisor, so the trial's top bit is a clean borrow flag.
    always_comb begin
        divShift = {acc[WIDTH-1:0], lowReg[WIDTH-1]};
        divTrial = divShift - {1'b0, mReg};
        if (divTrial[WIDTH]) begin
            divAcc = divShift;
            divLow = {lowReg[WIDTH-2:0], 1'b0};
        end else begin
            divAcc = divTrial;
            divLow = {lowReg[WIDTH-2:0], 1'b1};
        end
    end
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            count    <= '0;
            acc      <= '0;
            lowReg   <= '0;
            mReg     <= '0;
            qm1      <= 1'b0;
            noWrite  <= 1'b0;
            zeroFlag <= 1'b0;
            hi_out   <= '0;
            lo_out   <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
`ifdef MULT_DIV_SEQ_DIV_EN
            opDiv    <= 1'b0;
            negQuo   <= 1'b0;
            negRem   <= 1'b0;
`endif
        end else begin
            done     <= finNow;
            div_zero <= finNow && zeroFlag;
            unique case (state)
                IDLE: if (start) begin
                    count    <= '0;
                    acc      <= '0;
                    qm1      <= 1'b0;
                    noWrite  <= skipRun;
                    zeroFlag <= zeroReq;
`ifdef MULT_DIV_SEQ_DIV_EN
                    opDiv    <= op;
                    negQuo   <= opA[WIDTH-1] ^ opB[WIDTH-1];
                    negRem   <= opA[WIDTH-1];
                    lowReg   <= op ? magOf(opA) : opA;
                    mReg     <= op ? magOf(opB) : opB;
`else
                    lowReg   <= opA;
                    mReg     <= opB;
`endif
                end
                RUN: begin
                    count <= count + 6'd1;
`ifdef MULT_DIV_SEQ_DIV_EN
                    if (opDiv) begin
                        acc    <= divAcc;
                        lowReg <= divLow;
                    end else begin
                        acc    <= boothAcc;
                        lowReg <= boothLow;
                        qm1    <= lowReg[0];
                    end
`else
                    acc    <= boothAcc;
                    lowReg <= boothLow;
                    qm1    <= lowReg[0];
`endif
                end
                FIN: if (!noWrite) begin
`ifdef MULT_DIV_SEQ_DIV_EN
                    if (opDiv) begin
                        hi_out <= negRem ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
                        lo_out <= negQuo ? -lowReg : lowReg;
                    end else begin
                        hi_out <= acc[WIDTH-1:0];
                        lo_out <= lowReg;
                    end
`else
                    hi_out <= acc[WIDTH-1:0];
                    lo_out <= lowReg;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule
